// File: rtl/mii_rx_frame_checker_if.sv
// MII receive-side bundle: nibble input lane, reassembled byte stream, per-frame status and counters.
// The master drives the MII pins and observes results; the slave is the frame checker.
interface mii_rx_frame_checker_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       MII_RXD;
  logic             MII_RXDV;
  logic [7:0]       DOUT;
  logic             DOUT_VLD;
  logic             DOUT_SOF;
  logic             DOUT_EOF;
  logic             STAT_VLD;
  logic [15:0]      STAT_LEN;
  logic             STAT_CRC_ERR;
  logic             STAT_LEN_ERR;
  logic             STAT_ALIGN_ERR;
  logic [CNT_W-1:0] FRAME_CNT;
  logic [CNT_W-1:0] ERR_CNT;

  modport master (
    output MII_RXD, MII_RXDV,
    input  DOUT, DOUT_VLD, DOUT_SOF, DOUT_EOF,
    input  STAT_VLD, STAT_LEN, STAT_CRC_ERR, STAT_LEN_ERR, STAT_ALIGN_ERR,
    input  FRAME_CNT, ERR_CNT
  );

  modport slave (
    input  MII_RXD, MII_RXDV,
    output DOUT, DOUT_VLD, DOUT_SOF, DOUT_EOF,
    output STAT_VLD, STAT_LEN, STAT_CRC_ERR, STAT_LEN_ERR, STAT_ALIGN_ERR,
    output FRAME_CNT, ERR_CNT
  );
endinterface

// File: rtl/mii_rx_frame_checker.sv
// MII frame sink: strips preamble/SFD, rebuilds bytes, checks FCS residue, length and nibble
// alignment, and reports per-frame status with saturating frame/error counters.
module mii_rx_frame_checker #(
  parameter int MIN_PRE = 2,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input logic                   CLK,
  input logic                   RSTN,
  mii_rx_frame_checker_if.slave mii
);
  localparam int               PRE_W       = $clog2(MIN_PRE + 1) + 1;
  localparam logic [PRE_W-1:0] MIN_PRE_C   = PRE_W'(MIN_PRE);
  localparam logic [15:0]      MIN_LEN_C   = 16'(MIN_LEN);
  localparam logic [15:0]      MAX_LEN_C   = 16'(MAX_LEN);
  localparam logic [31:0]      CRC_RESIDUE = 32'hC704DD7B;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t           state_q, state_d;
  logic             rxdv_prev_q, rxdv_prev_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             phase_q, phase_d;
  logic             hold_vld_q, hold_vld_d;
  logic             first_q, first_d;
  logic             stat_pend_q, stat_pend_d;
  logic [15:0]      byte_cnt_q, byte_cnt_d;
  logic [3:0]       low_q, low_d;
  logic [7:0]       hold_q, hold_d;
  logic [31:0]      crc_q, crc_d;
  logic [7:0]       dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d, sof_q, sof_d, eof_q, eof_d;
  logic             stat_vld_q, stat_vld_d;
  logic [15:0]      stat_len_q, stat_len_d;
  logic             crc_err_q, crc_err_d, len_err_q, len_err_d, align_err_q, align_err_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
  logic             crc_bad, len_bad;

  // Non-reflected register fed LSB-first, so a good frame leaves the standard residue.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    rxdv_prev_d = mii.MII_RXDV;
    pre_cnt_d   = pre_cnt_q;
    phase_d     = phase_q;
    hold_vld_d  = hold_vld_q;
    first_d     = first_q;
    stat_pend_d = 1'b0;
    byte_cnt_d  = byte_cnt_q;
    low_d       = low_q;
    hold_d      = hold_q;
    crc_d       = crc_q;
    dout_d      = dout_q;
    dout_vld_d  = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    stat_vld_d  = 1'b0;
    stat_len_d  = stat_len_q;
    crc_err_d   = crc_err_q;
    len_err_d   = len_err_q;
    align_err_d = align_err_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    crc_bad     = (crc_q != CRC_RESIDUE) || (byte_cnt_q < 16'd4);
    len_bad     = (byte_cnt_q < MIN_LEN_C) || (byte_cnt_q > MAX_LEN_C);

    // Frame bookkeeping is untouched until the next SFD, so status is taken one cycle late.
    if (stat_pend_q) begin
      stat_vld_d  = 1'b1;
      stat_len_d  = byte_cnt_q;
      crc_err_d   = crc_bad;
      len_err_d   = len_bad;
      align_err_d = phase_q;
      if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
      if ((crc_bad || len_bad || phase_q) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (mii.MII_RXDV && !rxdv_prev_q) begin
          if (mii.MII_RXD == 4'h5) begin
            state_d   = PRE;
            pre_cnt_d = PRE_W'(1);
          end else begin
            state_d = DROP;
          end
        end
      end
      PRE: begin
        if (!mii.MII_RXDV) begin
          state_d = IDLE;
        end else if (mii.MII_RXD == 4'h5) begin
          if (pre_cnt_q != '1) pre_cnt_d = pre_cnt_q + 1'b1;
        end else if ((mii.MII_RXD == 4'hD) && (pre_cnt_q >= MIN_PRE_C)) begin
          state_d    = DATA;
          crc_d      = 32'hFFFF_FFFF;
          byte_cnt_d = '0;
          phase_d    = 1'b0;
          hold_vld_d = 1'b0;
          first_d    = 1'b1;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (!mii.MII_RXDV) begin
          if (hold_vld_q) begin
            dout_d     = hold_q;
            dout_vld_d = 1'b1;
            sof_d      = first_q;
            eof_d      = 1'b1;
            first_d    = 1'b0;
            hold_vld_d = 1'b0;
          end
          stat_pend_d = 1'b1;
          state_d     = IDLE;
        end else if (!phase_q) begin
          low_d   = mii.MII_RXD;
          phase_d = 1'b1;
          if (hold_vld_q) begin
            dout_d     = hold_q;
            dout_vld_d = 1'b1;
            sof_d      = first_q;
            first_d    = 1'b0;
            hold_vld_d = 1'b0;
          end
        end else begin
          hold_d     = {mii.MII_RXD, low_q};
          hold_vld_d = 1'b1;
          crc_d      = crc_byte(crc_q, {mii.MII_RXD, low_q});
          phase_d    = 1'b0;
          if (byte_cnt_q != 16'hFFFF) byte_cnt_d = byte_cnt_q + 16'd1;
        end
      end
      DROP: begin
        if (!mii.MII_RXDV) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      rxdv_prev_q <= 1'b1;
      pre_cnt_q   <= '0;
      phase_q     <= 1'b0;
      hold_vld_q  <= 1'b0;
      first_q     <= 1'b0;
      stat_pend_q <= 1'b0;
      byte_cnt_q  <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      stat_vld_q  <= 1'b0;
      stat_len_q  <= '0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      align_err_q <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rxdv_prev_q <= rxdv_prev_d;
      pre_cnt_q   <= pre_cnt_d;
      phase_q     <= phase_d;
      hold_vld_q  <= hold_vld_d;
      first_q     <= first_d;
      stat_pend_q <= stat_pend_d;
      byte_cnt_q  <= byte_cnt_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      stat_vld_q  <= stat_vld_d;
      stat_len_q  <= stat_len_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
      align_err_q <= align_err_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Datapath registers are always qualified by control state, so they carry no reset.
  always_ff @(posedge CLK) begin
    low_q  <= low_d;
    hold_q <= hold_d;
    crc_q  <= crc_d;
  end

  assign mii.DOUT           = dout_q;
  assign mii.DOUT_VLD       = dout_vld_q;
  assign mii.DOUT_SOF       = sof_q;
  assign mii.DOUT_EOF       = eof_q;
  assign mii.STAT_VLD       = stat_vld_q;
  assign mii.STAT_LEN       = stat_len_q;
  assign mii.STAT_CRC_ERR   = crc_err_q;
  assign mii.STAT_LEN_ERR   = len_err_q;
  assign mii.STAT_ALIGN_ERR = align_err_q;
  assign mii.FRAME_CNT      = frame_cnt_q;
  assign mii.ERR_CNT        = err_cnt_q;
endmodule

// File: tb/tb_mii_rx_frame_checker.sv
// Bench for mii_rx_frame_checker: drives nibble-level frames and compares the byte stream and
// per-frame status against a byte-level reference model of Ethernet framing and FCS.
module tb_mii_rx_frame_checker;
  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [15:0] len;
    logic        crc;
    logic        lerr;
    logic        aerr;
    logic        eofp;
  } stat_t;

  logic CLK = 1'b0;
  logic RSTN;
  always #5 CLK = ~CLK;

  mii_rx_frame_checker_if #(.CNT_W(16)) mi ();

  mii_rx_frame_checker #(
    .MIN_PRE(2), .MIN_LEN(64), .MAX_LEN(1518), .CNT_W(16)
  ) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .mii (mi)
  );

  logic [9:0] exp_dout[$];
  logic [9:0] act_dout[$];
  stat_t      exp_stat[$];
  stat_t      act_stat[$];
  int         errors = 0;
  int         checks = 0;
  int         exp_frames = 0;
  int         exp_errs = 0;
  logic       eof_prev = 1'b0;

  // Output monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (mi.DOUT_VLD === 1'b1) act_dout.push_back({mi.DOUT_SOF, mi.DOUT_EOF, mi.DOUT});
    if (mi.STAT_VLD === 1'b1)
      act_stat.push_back('{mi.STAT_LEN, mi.STAT_CRC_ERR, mi.STAT_LEN_ERR, mi.STAT_ALIGN_ERR, eof_prev});
    eof_prev = (mi.DOUT_VLD === 1'b1) && (mi.DOUT_EOF === 1'b1);
  end

  // Reference: standard reflected Ethernet CRC-32, returned complemented (the FCS value).
  function automatic logic [31:0] crc32(input bq_t b, input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t with_fcs(input bq_t p);
    bq_t         r;
    logic [31:0] c;
    r = p;
    c = crc32(p, p.size());
    for (int k = 0; k < 4; k++) r.push_back(c[8*k +: 8]);
    return r;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t r;
    for (int i = 0; i < n; i++) r.push_back(8'($urandom));
    return r;
  endfunction

  // Frame-level expectations: every byte out in order, SOF on byte 0, EOF on the last byte
  // only when no dangling nibble followed it, then one status record.
  task automatic model_frame(input bq_t b, input bit extra);
    int    n;
    logic  ok;
    stat_t s;
    n  = b.size();
    ok = 1'b0;
    for (int i = 0; i < n; i++)
      exp_dout.push_back({1'(i == 0), 1'((i == n - 1) && !extra), b[i]});
    if (n >= 4) ok = (crc32(b, n - 4) == {b[n-1], b[n-2], b[n-3], b[n-4]});
    s.len  = (n > 65535) ? 16'hFFFF : 16'(n);
    s.crc  = !ok;
    s.lerr = (n < 64) || (n > 1518);
    s.aerr = extra;
    s.eofp = (n > 0) && !extra;
    exp_stat.push_back(s);
    exp_frames++;
    if (s.crc || s.lerr || s.aerr) exp_errs++;
  endtask

  function automatic int dout_diffs();
    int d, m;
    m = (act_dout.size() < exp_dout.size()) ? act_dout.size() : exp_dout.size();
    d = (act_dout.size() > exp_dout.size()) ? act_dout.size() - m : exp_dout.size() - m;
    for (int i = 0; i < m; i++) if (act_dout[i] !== exp_dout[i]) d++;
    return d;
  endfunction

  function automatic int stat_diffs();
    int d, m;
    m = (act_stat.size() < exp_stat.size()) ? act_stat.size() : exp_stat.size();
    d = (act_stat.size() > exp_stat.size()) ? act_stat.size() - m : exp_stat.size() - m;
    for (int i = 0; i < m; i++) if (act_stat[i] !== exp_stat[i]) d++;
    return d;
  endfunction

  function automatic stat_t first_stat();
    stat_t s;
    s = '0;
    if (act_stat.size() > 0) s = act_stat[0];
    return s;
  endfunction

  task automatic clear_q();
    exp_dout.delete();
    act_dout.delete();
    exp_stat.delete();
    act_stat.delete();
  endtask

  task automatic nib(input logic [3:0] v);
    mi.MII_RXD  = v;
    mi.MII_RXDV = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic gap(input int n);
    mi.MII_RXD  = 4'h0;
    mi.MII_RXDV = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // 7x 0x55 + 0xD5 on the wire: fifteen 0x5 nibbles then 0xD.
  task automatic send(input bq_t b, input bit extra, input int rst_at);
    for (int k = 0; k < 15; k++) nib(4'h5);
    nib(4'hD);
    for (int i = 0; i < b.size(); i++) begin
      if (i == rst_at) RSTN = 1'b0;
      nib(b[i][3:0]);
      RSTN = 1'b1;
      nib(b[i][7:4]);
    end
    if (extra) nib(4'hA);
  endtask

  task automatic settle();
    for (int k = 0; k < 40 && act_stat.size() < exp_stat.size(); k++) @(negedge CLK);
    repeat (4) @(negedge CLK);
  endtask

  function automatic bq_t good_frame();
    bq_t p;
    for (int i = 0; i < 60; i++) p.push_back(8'(i));
    return with_fcs(p);
  endfunction

  task automatic test_reset();
    clear_q();
    RSTN        = 1'b0;
    mi.MII_RXDV = 1'b1;
    mi.MII_RXD  = 4'h5;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({mi.DOUT, mi.DOUT_VLD, mi.DOUT_SOF, mi.DOUT_EOF, mi.STAT_VLD, mi.STAT_LEN,
         mi.STAT_CRC_ERR, mi.STAT_LEN_ERR, mi.STAT_ALIGN_ERR, mi.FRAME_CNT, mi.ERR_CNT} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: DOUT=%h VLD=%b STAT_VLD=%b LEN=%0d FRAME_CNT=%0d ERR_CNT=%0d, want all 0",
               mi.DOUT, mi.DOUT_VLD, mi.STAT_VLD, mi.STAT_LEN, mi.FRAME_CNT, mi.ERR_CNT);
    end
    // Release reset mid-frame: the frame already on the wire must be ignored.
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    send(good_frame(), 1'b0, -1);
    gap(2);
    settle();
    checks++;
    if (act_dout.size() !== 0 || act_stat.size() !== 0) begin
      errors++;
      $display("FAIL reset_inflight: got %0d bytes %0d stats, want 0 and 0", act_dout.size(), act_stat.size());
    end
    checks++;
    if (mi.FRAME_CNT !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt: got %0d want 0", mi.FRAME_CNT);
    end
  endtask

  task automatic test_good();
    stat_t s;
    clear_q();
    model_frame(good_frame(), 1'b0);
    send(good_frame(), 1'b0, -1);
    gap(2);
    settle();
    s = first_stat();
    checks++;
    if (dout_diffs() !== 0) begin
      errors++;
      $display("FAIL good_dout: %0d records differ, got %0d bytes want %0d", dout_diffs(), act_dout.size(), exp_dout.size());
    end
    checks++;
    if (stat_diffs() !== 0) begin
      errors++;
      $display("FAIL good_stat: got %0d stats, first=%h want %h", act_stat.size(), s, exp_stat[0]);
    end
    checks++;
    if (s.len !== 16'd64 || s.crc !== 1'b0 || s.lerr !== 1'b0 || s.aerr !== 1'b0) begin
      errors++;
      $display("FAIL good_fields: len=%0d crc=%b len_err=%b align=%b, want 64 0 0 0", s.len, s.crc, s.lerr, s.aerr);
    end
    checks++;
    if (mi.STAT_LEN !== 16'd64) begin
      errors++;
      $display("FAIL good_stat_hold: STAT_LEN=%0d want 64", mi.STAT_LEN);
    end
    checks++;
    if (mi.FRAME_CNT !== 16'(exp_frames) || mi.ERR_CNT !== 16'(exp_errs)) begin
      errors++;
      $display("FAIL good_counters: frames=%0d errs=%0d want %0d %0d", mi.FRAME_CNT, mi.ERR_CNT, exp_frames, exp_errs);
    end
  endtask

  task automatic test_crc_err();
    bq_t   f;
    stat_t s;
    clear_q();
    f     = good_frame();
    f[10] = f[10] ^ 8'h01;
    model_frame(f, 1'b0);
    send(f, 1'b0, -1);
    gap(2);
    settle();
    s = first_stat();
    checks++;
    if (dout_diffs() !== 0 || stat_diffs() !== 0) begin
      errors++;
      $display("FAIL crc_stream: dout diffs=%0d stat diffs=%0d, want 0 0", dout_diffs(), stat_diffs());
    end
    checks++;
    if (s.crc !== 1'b1 || s.len !== 16'd64) begin
      errors++;
      $display("FAIL crc_flag: crc=%b len=%0d want 1 64", s.crc, s.len);
    end
    checks++;
    if (mi.ERR_CNT !== 16'(exp_errs)) begin
      errors++;
      $display("FAIL crc_err_cnt: got %0d want %0d", mi.ERR_CNT, exp_errs);
    end
  endtask

  task automatic test_align();
    stat_t s;
    clear_q();
    model_frame(good_frame(), 1'b1);
    send(good_frame(), 1'b1, -1);
    gap(2);
    settle();
    s = first_stat();
    checks++;
    if (dout_diffs() !== 0 || act_dout.size() !== 64) begin
      errors++;
      $display("FAIL align_dout: got %0d bytes (diffs=%0d) want 64", act_dout.size(), dout_diffs());
    end
    checks++;
    if (stat_diffs() !== 0 || s.aerr !== 1'b1 || s.crc !== 1'b0 || s.len !== 16'd64) begin
      errors++;
      $display("FAIL align_stat: align=%b crc=%b len=%0d want 1 0 64", s.aerr, s.crc, s.len);
    end
  endtask

  task automatic test_bad_preamble();
    bq_t f;
    clear_q();
    f = with_fcs(rand_bytes(60));
    nib(4'h5);
    nib(4'h5);
    nib(4'h7);
    for (int k = 0; k < 15; k++) nib(4'h5);
    nib(4'hD);
    foreach (f[i]) begin
      nib(f[i][3:0]);
      nib(f[i][7:4]);
    end
    gap(1);
    f = with_fcs(rand_bytes(60));
    model_frame(f, 1'b0);
    send(f, 1'b0, -1);
    gap(2);
    settle();
    checks++;
    if (dout_diffs() !== 0 || stat_diffs() !== 0) begin
      errors++;
      $display("FAIL badpre_stream: %0d bytes %0d stats (diffs %0d/%0d), want 64 and 1",
               act_dout.size(), act_stat.size(), dout_diffs(), stat_diffs());
    end
    checks++;
    if (mi.FRAME_CNT !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL badpre_frame_cnt: got %0d want %0d", mi.FRAME_CNT, exp_frames);
    end
  endtask

  task automatic test_length();
    bq_t   f;
    stat_t s;
    clear_q();
    f = with_fcs(rand_bytes(28));
    model_frame(f, 1'b0);
    send(f, 1'b0, -1);
    gap(2);
    settle();
    s = first_stat();
    checks++;
    if (stat_diffs() !== 0 || s.len !== 16'd32 || s.lerr !== 1'b1 || s.crc !== 1'b0) begin
      errors++;
      $display("FAIL runt_stat: len=%0d len_err=%b crc=%b want 32 1 0", s.len, s.lerr, s.crc);
    end
    clear_q();
    f = with_fcs(rand_bytes(1518));
    model_frame(f, 1'b0);
    send(f, 1'b0, -1);
    gap(2);
    settle();
    s = first_stat();
    checks++;
    if (dout_diffs() !== 0) begin
      errors++;
      $display("FAIL oversize_dout: %0d records differ, got %0d bytes want 1522", dout_diffs(), act_dout.size());
    end
    checks++;
    if (stat_diffs() !== 0 || s.len !== 16'd1522 || s.lerr !== 1'b1 || s.crc !== 1'b0) begin
      errors++;
      $display("FAIL oversize_stat: len=%0d len_err=%b crc=%b want 1522 1 0", s.len, s.lerr, s.crc);
    end
  endtask

  task automatic test_back_to_back();
    int  lens[6];
    bq_t f;
    bit  x;
    clear_q();
    lens = '{0, 1, 3, 64 + int'($urandom_range(0, 15)), 9, 70 + int'($urandom_range(0, 30))};
    for (int j = 0; j < 6; j++) begin
      f = (lens[j] >= 8) ? with_fcs(rand_bytes(lens[j] - 4)) : rand_bytes(lens[j]);
      x = (j == 4);
      model_frame(f, x);
      send(f, x, -1);
      gap(1);
    end
    gap(2);
    settle();
    checks++;
    if (dout_diffs() !== 0) begin
      errors++;
      $display("FAIL b2b_dout: %0d records differ, got %0d want %0d", dout_diffs(), act_dout.size(), exp_dout.size());
    end
    checks++;
    if (stat_diffs() !== 0) begin
      errors++;
      $display("FAIL b2b_stat: %0d records differ, got %0d want %0d", stat_diffs(), act_stat.size(), exp_stat.size());
    end
    checks++;
    if (mi.FRAME_CNT !== 16'(exp_frames) || mi.ERR_CNT !== 16'(exp_errs)) begin
      errors++;
      $display("FAIL b2b_counters: frames=%0d errs=%0d want %0d %0d", mi.FRAME_CNT, mi.ERR_CNT, exp_frames, exp_errs);
    end
  endtask

  task automatic test_reset_midframe();
    bq_t f;
    clear_q();
    send(with_fcs(rand_bytes(60)), 1'b0, 20);
    gap(1);
    repeat (3) @(negedge CLK);
    checks++;
    if (act_stat.size() !== 0 || mi.FRAME_CNT !== 16'd0) begin
      errors++;
      $display("FAIL abort_stat: got %0d stats FRAME_CNT=%0d, want 0 0", act_stat.size(), mi.FRAME_CNT);
    end
    clear_q();
    exp_frames = 0;
    exp_errs   = 0;
    f = with_fcs(rand_bytes(60));
    model_frame(f, 1'b0);
    send(f, 1'b0, -1);
    gap(2);
    settle();
    checks++;
    if (dout_diffs() !== 0 || stat_diffs() !== 0) begin
      errors++;
      $display("FAIL abort_next_frame: dout diffs=%0d stat diffs=%0d want 0 0", dout_diffs(), stat_diffs());
    end
    checks++;
    if (mi.FRAME_CNT !== 16'd1 || mi.ERR_CNT !== 16'd0) begin
      errors++;
      $display("FAIL abort_counters: frames=%0d errs=%0d want 1 0", mi.FRAME_CNT, mi.ERR_CNT);
    end
  endtask

  initial begin
    RSTN        = 1'b0;
    mi.MII_RXD  = 4'h0;
    mi.MII_RXDV = 1'b0;
    test_reset();
    test_good();
    test_crc_err();
    test_align();
    test_bad_preamble();
    test_length();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
